// File: rtl/rx_dsp_pkg.sv
// Shared definitions for the receive DSP frame buffer: FSM state encoding
// and default sizing constants.
package rx_dsp_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IRQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Default sizing
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_DEPTH     = 256;
    localparam int DEF_BLOCK_LEN = 64;
    localparam int DEF_IRQ_WIDTH = 100;

endpackage

// File: rtl/rx_sync_fifo.sv
// Single-clock RAM FIFO with registered read data, level tracking and a
// synchronous flush that wins over any write or read in the same cycle.
// A write while full is accepted only when a read frees a slot that cycle.
module rx_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       level,
    output logic              empty,
    output logic              wr_accept,
    output logic              rd_accept
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              full;

    assign full      = (level_q == LEVEL_FULL);
    assign empty     = (level_q == '0);
    assign rd_accept = rd_en && !empty && !flush;
    assign wr_accept = wr_en && (!full || rd_accept) && !flush;
    assign level     = level_q;
    assign rd_data   = rd_data_q;

    // Next-state for pointers, level and the read data register
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem[rd_ptr_q];
        end
        case ({wr_accept, rd_accept})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    // Storage array; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_q] <= wr_data;
    end

    // Pointer, level and read-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/rx_dsp_frame_buf.sv
// Receive sample buffer for the DSP: queues {q,i} words, raises a stretched
// block-ready interrupt once a block is queued and tracks the DSP drain.
// Optional statistics (irq_count, drop_count) exist when RX_DSP_IRQ_STAT_EN
// is defined.
module rx_dsp_frame_buf
    import rx_dsp_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN,
    parameter int IRQ_WIDTH = DEF_IRQ_WIDTH
) (
    input  logic                     clk_50m,
    input  logic                     cfg_rst,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic                     sample_in_en,
    input  logic                     slot_interrupt,
    input  logic                     dsp_rd_en,
    output logic [DATA_W-1:0]        dsp_rd_data,
    output logic                     dsp_receive_interrupt,
    output logic [$clog2(DEPTH):0]   fifo_level,
`ifdef RX_DSP_IRQ_STAT_EN
    output logic [10:0]              irq_count,
    output logic [15:0]              drop_count,
`endif
    output logic                     overflow,
    output logic                     underflow
);

    localparam int LVL_W     = $clog2(DEPTH) + 1;
    localparam int IRQ_CNT_W = $clog2(IRQ_WIDTH + 1);
    localparam int RD_CNT_W  = $clog2(BLOCK_LEN + 1);

    logic                 fifo_empty, wr_accept, rd_accept;
    logic                 wr_drop, rd_empty_hit, level_ready, irq_start;
    logic [1:0]           state_q, state_d;
    logic [IRQ_CNT_W-1:0] irq_cnt_q, irq_cnt_d;
    logic [RD_CNT_W-1:0]  rd_cnt_q, rd_cnt_d, rd_cnt_inc;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;

    rx_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_50m),
        .rst       (cfg_rst),
        .flush     (slot_interrupt),
        .wr_en     (sample_in_en),
        .wr_data   (sample_in),
        .rd_en     (dsp_rd_en),
        .rd_data   (dsp_rd_data),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .wr_accept (wr_accept),
        .rd_accept (rd_accept)
    );

    // A flush cycle is neither a drop nor an underflow: the access is discarded
    assign wr_drop      = sample_in_en && !wr_accept && !slot_interrupt;
    assign rd_empty_hit = dsp_rd_en && fifo_empty && !slot_interrupt;
    assign level_ready  = (fifo_level >= LVL_W'(BLOCK_LEN));

    assign dsp_receive_interrupt = (state_q == ST_IRQ);
    assign overflow              = overflow_q;
    assign underflow             = underflow_q;

    // Block FSM, interrupt/read counters and sticky flags; flush overrides all
    always_comb begin
        state_d     = state_q;
        irq_cnt_d   = irq_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        overflow_d  = overflow_q || wr_drop;
        underflow_d = underflow_q || rd_empty_hit;
        irq_start   = 1'b0;
        // Reads beyond one block (possible during IRQ) do not overcount
        rd_cnt_inc  = rd_cnt_q;
        if (rd_accept && (rd_cnt_q != RD_CNT_W'(BLOCK_LEN)))
            rd_cnt_inc = rd_cnt_q + RD_CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (level_ready) begin
                    state_d   = ST_IRQ;
                    irq_cnt_d = '0;
                    irq_start = 1'b1;
                end
            end
            ST_IRQ: begin
                rd_cnt_d = rd_cnt_inc;
                if (irq_cnt_q == IRQ_CNT_W'(IRQ_WIDTH - 1))
                    state_d = ST_DRAIN;
                else
                    irq_cnt_d = irq_cnt_q + IRQ_CNT_W'(1);
            end
            ST_DRAIN: begin
                if (rd_cnt_inc == RD_CNT_W'(BLOCK_LEN)) begin
                    rd_cnt_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (slot_interrupt) begin
            state_d     = ST_IDLE;
            irq_cnt_d   = '0;
            rd_cnt_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            irq_start   = 1'b0;
        end
    end

    // Control registers
    always_ff @(posedge clk_50m or posedge cfg_rst) begin
        if (cfg_rst) begin
            state_q     <= ST_IDLE;
            irq_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_cnt_q   <= irq_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef RX_DSP_IRQ_STAT_EN
    logic [10:0] irq_count_q, irq_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    assign irq_count  = irq_count_q;
    assign drop_count = drop_count_q;

    // Saturating statistics counters, cleared at each slot boundary
    always_comb begin
        irq_count_d  = irq_count_q;
        drop_count_d = drop_count_q;
        if (irq_start && (irq_count_q != 11'h7FF))
            irq_count_d = irq_count_q + 11'd1;
        if (wr_drop && (drop_count_q != 16'hFFFF))
            drop_count_d = drop_count_q + 16'd1;
        if (slot_interrupt) begin
            irq_count_d  = '0;
            drop_count_d = '0;
        end
    end

    // Statistics registers
    always_ff @(posedge clk_50m or posedge cfg_rst) begin
        if (cfg_rst) begin
            irq_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            irq_count_q  <= irq_count_d;
            drop_count_q <= drop_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_rx_dsp_frame_buf.sv
// Directed bench for rx_dsp_frame_buf with a queue scoreboard of written
// words; also exercises the statistics ports when RX_DSP_IRQ_STAT_EN is set.
module tb_rx_dsp_frame_buf;

    localparam int DEPTH     = 256;
    localparam int BLOCK_LEN = 64;
    localparam int IRQ_WIDTH = 100;

    logic        clk_50m = 1'b0;
    logic        cfg_rst = 1'b1;
    logic [31:0] sample_in = '0;
    logic        sample_in_en = 1'b0;
    logic        slot_interrupt = 1'b0;
    logic        dsp_rd_en = 1'b0;
    logic [31:0] dsp_rd_data;
    logic        dsp_receive_interrupt;
    logic [8:0]  fifo_level;
    logic        overflow, underflow;
`ifdef RX_DSP_IRQ_STAT_EN
    logic [10:0] irq_count;
    logic [15:0] drop_count;
`endif

    rx_dsp_frame_buf dut (
        .clk_50m               (clk_50m),
        .cfg_rst               (cfg_rst),
        .sample_in             (sample_in),
        .sample_in_en          (sample_in_en),
        .slot_interrupt        (slot_interrupt),
        .dsp_rd_en             (dsp_rd_en),
        .dsp_rd_data           (dsp_rd_data),
        .dsp_receive_interrupt (dsp_receive_interrupt),
        .fifo_level            (fifo_level),
`ifdef RX_DSP_IRQ_STAT_EN
        .irq_count             (irq_count),
        .drop_count            (drop_count),
`endif
        .overflow              (overflow),
        .underflow             (underflow)
    );

    always #10 clk_50m = ~clk_50m;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_q[$];
    logic [31:0] exp_rd = '0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;
    int          m_drops = 0;
    logic        irq_prev = 1'b0;
    int          irq_rises = 0;
    int          irq_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; scoreboard update and per-cycle checks
    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic s);
        logic was_full, was_empty, rd_ok, wr_ok;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        sample_in = d; sample_in_en = w; dsp_rd_en = r; slot_interrupt = s;
        @(posedge clk_50m);
        #1;
        sample_in_en = 1'b0; dsp_rd_en = 1'b0; slot_interrupt = 1'b0;
        if (s) begin
            model_q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_drops = 0;
        end else begin
            rd_ok = r && !was_empty;
            wr_ok = w && (!was_full || rd_ok);
            if (rd_ok) exp_rd = model_q.pop_front();
            if (r && was_empty) m_unf = 1'b1;
            if (w && !wr_ok) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
            if (wr_ok) model_q.push_back(d);
        end
        check("level", 32'(fifo_level), 32'(model_q.size()));
        check("rd_data", dsp_rd_data, exp_rd);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`ifdef RX_DSP_IRQ_STAT_EN
        check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
        if (dsp_receive_interrupt && !irq_prev) irq_rises++;
        irq_run  = dsp_receive_interrupt ? irq_run + 1 : 0;
        irq_prev = dsp_receive_interrupt;
    endtask

    // Expects the interrupt to rise on the next cycle and stay high IRQ_WIDTH cycles
    task automatic check_irq_pulse(input string tag);
        int n;
        check({tag, "_pre"}, 32'(dsp_receive_interrupt), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        check({tag, "_rise"}, 32'(dsp_receive_interrupt), 32'd1);
        n = 0;
        while (dsp_receive_interrupt && n < 300) begin
            n++;
            step(1'b0, '0, 1'b0, 1'b0);
        end
        check({tag, "_width"}, 32'(n), 32'(IRQ_WIDTH));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        // Reset state
        #15;
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_rd_data", dsp_rd_data, 32'd0);
        check("rst_irq", 32'(dsp_receive_interrupt), 32'd0);
        check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        #10 cfg_rst = 1'b0;

        // Test 1: one block, interrupt width, in-order drain
        for (int i = 0; i < BLOCK_LEN; i++) step(1'b1, {16'(i), 16'(i)}, 1'b0, 1'b0);
        check_irq_pulse("t1_irq");
`ifdef RX_DSP_IRQ_STAT_EN
        check("t1_irq_count", 32'(irq_count), 32'd1);
`endif
        for (int i = 0; i < BLOCK_LEN; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t1_last_word", dsp_rd_data, 32'h003F_003F);
        check("t1_level_end", 32'(fifo_level), 32'd0);

        // Test 3: read while empty
        step(1'b0, '0, 1'b1, 1'b0);
        check("t3_underflow", 32'(underflow), 32'd1);
        check("t3_rd_hold", dsp_rd_data, 32'h003F_003F);
        step(1'b0, '0, 1'b0, 1'b1);

        // Test 2: overfill with no reads
        for (int i = 0; i < 300; i++) step(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0);
        check("t2_level", 32'(fifo_level), 32'd256);
        check("t2_overflow", 32'(overflow), 32'd1);
`ifdef RX_DSP_IRQ_STAT_EN
        check("t2_drop_count", 32'(drop_count), 32'd44);
`endif
        step(1'b0, '0, 1'b0, 1'b1);

        // Test 4: simultaneous write and read while full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h2000_0000 + i, 1'b0, 1'b0);
        step(1'b1, 32'hABCD_1234, 1'b1, 1'b0);
        check("t4_level", 32'(fifo_level), 32'd256);
        check("t4_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t4_new_word", dsp_rd_data, 32'hABCD_1234);
        step(1'b0, '0, 1'b0, 1'b1);

        // Test 5: two blocks queued, second interrupt after the first block drains
        irq_rises = 0;
        for (int i = 0; i < 2 * BLOCK_LEN; i++) step(1'b1, 32'h3000_0000 + i, 1'b0, 1'b0);
        guard = 0;
        while (dsp_receive_interrupt && guard < 300) begin
            guard++;
            step(1'b0, '0, 1'b0, 1'b0);
        end
        check("t5_one_irq", 32'(irq_rises), 32'd1);
        for (int i = 0; i < BLOCK_LEN; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t5_irq_low_at_64th", 32'(dsp_receive_interrupt), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t5_irq_second_rise", 32'(dsp_receive_interrupt), 32'd1);
        check("t5_two_irqs", 32'(irq_rises), 32'd2);
        step(1'b0, '0, 1'b0, 1'b1);

        // Test 6: slot boundary in the middle of an interrupt
        for (int i = 0; i < 70; i++) step(1'b1, 32'h4000_0000 + i, 1'b0, 1'b0);
        guard = 0;
        while (irq_run < 40 && guard < 300) begin
            guard++;
            step(1'b0, '0, 1'b0, 1'b0);
        end
        check("t6_irq_run", 32'(irq_run), 32'd40);
        step(1'b0, '0, 1'b0, 1'b1);
        check("t6_irq_cleared", 32'(dsp_receive_interrupt), 32'd0);
        check("t6_level_cleared", 32'(fifo_level), 32'd0);
`ifdef RX_DSP_IRQ_STAT_EN
        check("t6_irq_count_cleared", 32'(irq_count), 32'd0);
`endif
        step(1'b0, '0, 1'b0, 1'b0);
        check("t6_idle", 32'(dsp_receive_interrupt), 32'd0);
        for (int i = 0; i < BLOCK_LEN; i++) step(1'b1, 32'h5000_0000 + i, 1'b0, 1'b0);
        check_irq_pulse("t6_irq");
        for (int i = 0; i < BLOCK_LEN; i++) step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset while an interrupt is being signalled
        for (int i = 0; i < BLOCK_LEN; i++) step(1'b1, 32'h6000_0000 + i, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("ar_irq_before", 32'(dsp_receive_interrupt), 32'd1);
        #5 cfg_rst = 1'b1;
        #1;
        check("ar_irq", 32'(dsp_receive_interrupt), 32'd0);
        check("ar_level", 32'(fifo_level), 32'd0);
        check("ar_rd_data", dsp_rd_data, 32'd0);
        check("ar_flags", {30'd0, overflow, underflow}, 32'd0);
        model_q.delete();
        exp_rd = '0; m_ovf = 1'b0; m_unf = 1'b0; m_drops = 0;
        #6 cfg_rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("ar_no_pending_irq", 32'(dsp_receive_interrupt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
